// File: rtl/io_map_pkg.sv
// io_map_pkg: default I/O address map and button read-mode encodings for mmio_io_bridge
package io_map_pkg;
  localparam int OUT_ADDR_DEF    = 2000;
  localparam int IN_ADDR_DEF     = 2500;
  localparam int BTN_BASE_DEF    = 3000;
  localparam int BTN_STRIDE_DEF  = 1000;
  localparam int STATUS_ADDR_DEF = 8000;
  localparam int BTN_LEVEL       = 0;
  localparam int BTN_STICKY      = 1;
endpackage

// File: rtl/btn_conditioner.sv
// btn_conditioner: synchronise, debounce and capture presses of one push button
module btn_conditioner #(
  parameter int DB_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  input  logic clr_i,
  output logic level_o,
  output logic press_o
);
  localparam int CW = $clog2(DB_CYCLES + 1);
  logic [1:0] sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic level_q, level_d, press_q, press_d, flip;
  always_comb begin
    flip = sync_q[1] != level_q && cnt_q == CW'(DB_CYCLES - 1);
    cnt_d = (sync_q[1] == level_q || flip) ? '0 : cnt_q + 1'b1;
    level_d = level_q ^ flip;
    press_d = (level_d & ~level_q) | (press_q & ~clr_i);
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      sync_q <= '0;
      cnt_q <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], raw_i};
      cnt_q <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
    end
  assign level_o = level_q;
  assign press_o = press_q;
endmodule

// File: rtl/mmio_io_bridge.sv
// mmio_io_bridge: dmem-port I/O decode for buttons, a peripheral word in and a held word out
module mmio_io_bridge
  import io_map_pkg::*;
#(
  parameter int NUM_BTN     = 4,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int OUT_ADDR    = OUT_ADDR_DEF,
  parameter int IN_ADDR     = IN_ADDR_DEF,
  parameter int BTN_BASE    = BTN_BASE_DEF,
  parameter int BTN_STRIDE  = BTN_STRIDE_DEF,
  parameter int STATUS_ADDR = STATUS_ADDR_DEF,
  parameter int BTN_MODE    = BTN_LEVEL,
  parameter int DB_CYCLES   = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [ADDR_W-1:0]  address_i,
  input  logic [DATA_W-1:0]  wdata_i,
  input  logic               wren_i,
  output logic [DATA_W-1:0]  q_dmem_o,
  input  logic [DATA_W-1:0]  mem_rdata_i,
  output logic               mem_wren_o,
  input  logic [NUM_BTN-1:0] btn_raw_i,
  input  logic [DATA_W-1:0]  periph_in_i,
  output logic [DATA_W-1:0]  periph_out_o,
  output logic               periph_out_valid_o
);
  localparam logic [ADDR_W-1:0] OUT_A = ADDR_W'(OUT_ADDR);
  localparam logic [ADDR_W-1:0] IN_A  = ADDR_W'(IN_ADDR);
  localparam logic [ADDR_W-1:0] ST_A  = ADDR_W'(STATUS_ADDR);
  function automatic logic [ADDR_W-1:0] btn_addr(int n);
    return ADDR_W'(BTN_BASE + n * BTN_STRIDE);
  endfunction
  function automatic bit map_clash();
    bit c = OUT_A == IN_A || OUT_A == ST_A || IN_A == ST_A;
    for (int i = 0; i < NUM_BTN; i++) begin
      c |= btn_addr(i) == OUT_A || btn_addr(i) == IN_A || btn_addr(i) == ST_A;
      for (int j = i + 1; j < NUM_BTN; j++) c |= btn_addr(i) == btn_addr(j);
    end
    return c;
  endfunction
  if (map_clash() || NUM_BTN < 1 || NUM_BTN > 16 || DB_CYCLES < 1 || 2 * NUM_BTN > DATA_W) begin : g_bad_map
    $error("mmio_io_bridge: overlapping I/O addresses or illegal parameters");
  end
  logic [NUM_BTN-1:0] btn_hit, level, press, clr;
  logic in_hit, st_hit, io_hit, hit_out, hit_rd;
  logic [DATA_W-1:0] rd_word, periph_out_q, periph_out_d, io_q;
  logic valid_q, sel_io_q;
  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    assign btn_hit[i] = address_i == btn_addr(i);
    btn_conditioner #(.DB_CYCLES(DB_CYCLES)) u_cond (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .raw_i  (btn_raw_i[i]),
      .clr_i  (clr[i]),
      .level_o(level[i]),
      .press_o(press[i])
    );
  end
  always_comb begin
    in_hit = address_i == IN_A;
    st_hit = address_i == ST_A;
    io_hit = in_hit | st_hit | (|btn_hit) | (address_i == OUT_A);
    hit_out = wren_i & (address_i == OUT_A);
    hit_rd = ~wren_i & (in_hit | st_hit | (|btn_hit));
    periph_out_d = hit_out ? wdata_i : periph_out_q;
    rd_word = in_hit ? periph_in_i : st_hit ? DATA_W'({press, level}) : '0;
    for (int i = 0; i < NUM_BTN; i++)
      if (btn_hit[i]) rd_word = DATA_W'(BTN_MODE == BTN_STICKY ? press[i] : level[i]);
    // status reads always clear presses; a button read clears only in sticky mode
    clr = {NUM_BTN{hit_rd & st_hit}} | (BTN_MODE == BTN_STICKY ? btn_hit & {NUM_BTN{~wren_i}} : '0);
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      periph_out_q <= '0;
      valid_q <= 1'b0;
      sel_io_q <= 1'b0;
      io_q <= '0;
    end else begin
      periph_out_q <= periph_out_d;
      valid_q <= hit_out;
      sel_io_q <= hit_rd;
      io_q <= rd_word;
    end
  assign mem_wren_o = wren_i & ~io_hit;
  assign q_dmem_o = sel_io_q ? io_q : mem_rdata_i;
  assign periph_out_o = periph_out_q;
  assign periph_out_valid_o = valid_q;
endmodule

// File: tb/tb_mmio_io_bridge.sv
// tb_mmio_io_bridge: directed and random checks of both button modes against a behavioural model
module tb_mmio_io_bridge;
  localparam int NB = 4, DB = 16;
  logic clk = 1'b0, rst_n = 1'b0, wren = 1'b0;
  logic [31:0] address = '0, wdata = '0, mem_rdata = '0, periph_in = '0;
  logic [NB-1:0] btn_raw = '0;
  logic [31:0] q_lvl, q_stk, pout_lvl, pout_stk;
  logic mw_lvl, mw_stk, pv_lvl, pv_stk;
  int tests = 0, fails = 0;
  logic [31:0] m_out, m_io_lvl, m_io_stk;
  logic m_val, m_sel;
  logic [NB-1:0] m_lvl, m_pr_lvl, m_pr_stk;
  logic hist [NB][4096];
  int hn;
  always #5 clk = ~clk;
  mmio_io_bridge #(.BTN_MODE(0)) u_lvl (
    .clk_i(clk), .rst_ni(rst_n), .address_i(address), .wdata_i(wdata), .wren_i(wren),
    .q_dmem_o(q_lvl), .mem_rdata_i(mem_rdata), .mem_wren_o(mw_lvl), .btn_raw_i(btn_raw),
    .periph_in_i(periph_in), .periph_out_o(pout_lvl), .periph_out_valid_o(pv_lvl)
  );
  mmio_io_bridge #(.BTN_MODE(1)) u_stk (
    .clk_i(clk), .rst_ni(rst_n), .address_i(address), .wdata_i(wdata), .wren_i(wren),
    .q_dmem_o(q_stk), .mem_rdata_i(mem_rdata), .mem_wren_o(mw_stk), .btn_raw_i(btn_raw),
    .periph_in_i(periph_in), .periph_out_o(pout_stk), .periph_out_valid_o(pv_stk)
  );
  function automatic int btn_of(logic [31:0] a);
    for (int i = 0; i < NB; i++) if (a == 32'(3000 + i * 1000)) return i;
    return -1;
  endfunction
  function automatic bit is_io(logic [31:0] a);
    return a == 2000 || a == 2500 || a == 8000 || btn_of(a) >= 0;
  endfunction
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    m_out = '0; m_val = 1'b0; m_sel = 1'b0; m_io_lvl = '0; m_io_stk = '0;
    m_lvl = '0; m_pr_lvl = '0; m_pr_stk = '0;
    for (int i = 0; i < NB; i++) begin hist[i][0] = 1'b0; hist[i][1] = 1'b0; end
    hn = 2;
  endtask
  // advance the model across one rising edge using the inputs currently applied
  task automatic model_edge();
    int b = btn_of(address);
    bit rd = !wren && (address == 2500 || address == 8000 || b >= 0);
    logic [NB-1:0] clr_l, clr_s, old;
    bit flip;
    m_io_lvl = '0; m_io_stk = '0;
    if (address == 2500) begin m_io_lvl = periph_in; m_io_stk = periph_in; end
    else if (address == 8000) begin m_io_lvl = {24'b0, m_pr_lvl, m_lvl}; m_io_stk = {24'b0, m_pr_stk, m_lvl}; end
    else if (b >= 0) begin m_io_lvl = {31'b0, m_lvl[b]}; m_io_stk = {31'b0, m_pr_stk[b]}; end
    m_sel = rd;
    clr_l = (rd && address == 8000) ? '1 : '0;
    clr_s = clr_l;
    if (rd && b >= 0) clr_s[b] = 1'b1;
    for (int i = 0; i < NB; i++) hist[i][hn] = btn_raw[i];
    hn++;
    old = m_lvl;
    for (int i = 0; i < NB; i++) begin
      // the debouncer sees pins two edges late; accept after DB differing samples in a row
      flip = hn >= DB + 2;
      for (int j = hn - 2 - DB; flip && j <= hn - 3; j++) if (hist[i][j] == old[i]) flip = 0;
      if (flip) m_lvl[i] = ~old[i];
      m_pr_lvl[i] = (m_lvl[i] & ~old[i]) | (m_pr_lvl[i] & ~clr_l[i]);
      m_pr_stk[i] = (m_lvl[i] & ~old[i]) | (m_pr_stk[i] & ~clr_s[i]);
    end
    m_val = wren && address == 2000;
    if (m_val) m_out = wdata;
  endtask
  task automatic step(logic [31:0] a, logic w, logic [31:0] wd);
    address = a; wren = w; wdata = wd; mem_rdata = $urandom;
    #1;
    chk("mem_wren_lvl", {31'b0, mw_lvl}, {31'b0, w && !is_io(a)});
    chk("mem_wren_stk", {31'b0, mw_stk}, {31'b0, w && !is_io(a)});
    model_edge();
    @(posedge clk);
    @(negedge clk);
    chk("q_lvl", q_lvl, m_sel ? m_io_lvl : mem_rdata);
    chk("q_stk", q_stk, m_sel ? m_io_stk : mem_rdata);
    chk("pout", pout_lvl, m_out);
    chk("pout_stk", pout_stk, m_out);
    chk("pvalid", {31'b0, pv_lvl}, {31'b0, m_val});
    chk("pvalid_stk", {31'b0, pv_stk}, {31'b0, m_val});
  endtask
  task automatic idle(int n);
    for (int k = 0; k < n; k++) step(32'd100, 1'b0, 32'd0);
  endtask
  initial begin
    logic [31:0] addrs [9] = '{100, 2000, 2004, 2500, 3000, 4000, 5000, 6000, 8000};
    #3;
    chk("rst_q", q_lvl, mem_rdata);
    chk("rst_pout", pout_lvl, 32'd0);
    chk("rst_pvalid", {31'b0, pv_stk}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    step(32'd2000, 1'b1, 32'hDEADBEEF);
    chk("out_deadbeef", pout_lvl, 32'hDEADBEEF);
    chk("out_strobe", {31'b0, pv_lvl}, 32'd1);
    step(32'd2004, 1'b1, 32'h0BADF00D);
    chk("out_held", pout_lvl, 32'hDEADBEEF);
    chk("out_strobe_off", {31'b0, pv_lvl}, 32'd0);
    step(32'd2000, 1'b1, 32'd1);
    step(32'd2000, 1'b1, 32'd2);
    chk("b2b_last", pout_lvl, 32'd2);
    chk("b2b_strobe", {31'b0, pv_lvl}, 32'd1);
    step(32'd100, 1'b0, 32'd0);
    mem_rdata = 32'h12345678;
    #1 chk("ram_read", q_lvl, 32'h12345678);
    #4;
    periph_in = 32'hAA;
    step(32'd100, 1'b0, 32'd0);
    step(32'd2500, 1'b0, 32'd0);
    chk("periph_in", q_lvl, 32'hAA);
    step(32'd100, 1'b0, 32'd0);
    btn_raw[1] = 1'b1;
    idle(20);
    step(32'd4000, 1'b0, 32'd0);
    chk("btn1_level", q_lvl, 32'd1);
    chk("btn1_press", q_stk, 32'd1);
    btn_raw[1] = 1'b0;
    btn_raw[2] = 1'b1;
    idle(10);
    btn_raw[2] = 1'b0;
    idle(20);
    step(32'd5000, 1'b0, 32'd0);
    chk("glitch_level", q_lvl, 32'd0);
    chk("glitch_press", q_stk, 32'd0);
    btn_raw[0] = 1'b1;
    idle(20);
    btn_raw[0] = 1'b0;
    idle(20);
    step(32'd3000, 1'b0, 32'd0);
    chk("sticky_first", q_stk, 32'd1);
    chk("level_released", q_lvl, 32'd0);
    step(32'd3000, 1'b0, 32'd0);
    chk("sticky_cleared", q_stk, 32'd0);
    step(32'd8000, 1'b0, 32'd0);
    btn_raw[3] = 1'b1;
    step(32'd100, 1'b0, 32'd0);
    idle(DB);
    step(32'd8000, 1'b0, 32'd0);
    chk("status_preset", q_lvl, 32'd0);
    step(32'd8000, 1'b0, 32'd0);
    chk("status_setwins", q_lvl, 32'h88);
    chk("status_setwins_stk", q_stk, 32'h88);
    step(32'd8000, 1'b0, 32'd0);
    chk("status_cleared", q_stk, 32'h08);
    for (int k = 0; k < 400; k++) begin
      periph_in = $urandom;
      if ($urandom_range(0, 11) == 0) btn_raw[$urandom_range(0, NB - 1)] ^= 1'b1;
      step($urandom_range(0, 9) == 9 ? 32'($urandom_range(0, 9999)) : addrs[$urandom_range(0, 8)],
           $urandom_range(0, 2) == 0, $urandom);
    end
    btn_raw = '0;
    idle(20);
    step(32'd8000, 1'b0, 32'd0);
    step(32'd2000, 1'b1, 32'd5);
    chk("out_five", pout_lvl, 32'd5);
    btn_raw[0] = 1'b1;
    idle(5);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_pout", pout_lvl, 32'd0);
    chk("async_rst_pout_stk", pout_stk, 32'd0);
    chk("async_rst_q", q_stk, mem_rdata);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(32'd8000, 1'b0, 32'd0);
    chk("rst_status", q_lvl, 32'd0);
    idle(DB);
    step(32'd3000, 1'b0, 32'd0);
    chk("reaccept_early", q_lvl, 32'd0);
    step(32'd3000, 1'b0, 32'd0);
    chk("reaccept", q_lvl, 32'd1);
    chk("reaccept_press", q_stk, 32'd1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
